// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the double-dabble control slice: FSM state encoding,
// default operand width and BCD digit count helper.
package bin2bcd_pkg;

  localparam int unsigned N_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  // ceil(n * log10(2)) in fixed point, log10(2) ~= 0.30103
  function automatic int unsigned bcd_digits(input int unsigned n);
    return (n * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/bin2bcd_iter_cnt.sv
// Loadable iteration down-counter for the double-dabble controller.
// Loads N on ld, decrements on dec, saturates at zero.
module bin2bcd_iter_cnt #(
  parameter  int unsigned N  = 16,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld,
  input  logic          dec,
  output logic [CW-1:0] value,
  output logic          zero,
  output logic          last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (ld) begin
      value <= CW'(N);
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

  assign zero = (value == '0);
  assign last = (value == CW'(1));

endmodule

// File: rtl/bin2bcd_ctrl.sv
// Moore control FSM for the shift-and-add-3 binary-to-BCD datapath.
// Optional macro BIN2BCD_SKIP_ADD_EN skips add3 cycles when no digit is >= 5.
module bin2bcd_ctrl
  import bin2bcd_pkg::*;
#(
  parameter  int unsigned N  = N_DEFAULT,
  localparam int unsigned CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          any_ge5,
  output logic          ld,
  output logic          add3,
  output logic          shift,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] iter
);

  state_t state, nxt;
  logic   cnt_zero, cnt_last;

  // Strobes are registered copies of the state decode, so they can drive the counter directly.
  bin2bcd_iter_cnt #(.N(N)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .ld    (ld),
    .dec   (shift),
    .value (iter),
    .zero  (cnt_zero),
    .last  (cnt_last)
  );

`ifndef BIN2BCD_SKIP_ADD_EN
  logic unused_any_ge5;
  assign unused_any_ge5 = any_ge5;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = LOAD;
      LOAD:  nxt = ADD;
      ADD:   nxt = SHIFT;
      SHIFT: begin
        // zero is a guard only; the count always passes through 1 first
        if (cnt_last || cnt_zero) begin
          nxt = DONE;
        end else begin
`ifdef BIN2BCD_SKIP_ADD_EN
          nxt = any_ge5 ? ADD : SHIFT;
`else
          nxt = ADD;
`endif
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ld    <= 1'b0;
      add3  <= 1'b0;
      shift <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= nxt;
      ld    <= (nxt == LOAD);
      add3  <= (nxt == ADD);
      shift <= (nxt == SHIFT);
      busy  <= (nxt == LOAD) || (nxt == ADD) || (nxt == SHIFT);
      done  <= (nxt == DONE);
    end
  end

endmodule

// File: tb/tb_bin2bcd_ctrl.sv
// Scoreboard bench for bin2bcd_ctrl: stimulus queues expected strobe events,
// a negedge monitor pops and compares them and runs a behavioural datapath.
module tb_bin2bcd_ctrl;
  import bin2bcd_pkg::*;

  localparam int N  = 16;
  localparam int CW = $clog2(N + 1);
  localparam int D  = 5;
  localparam int W  = N + 4 * D;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          any_ge5;
  logic          ld, add3, shift, busy, done;
  logic [CW-1:0] iter;

  bin2bcd_ctrl #(.N(N)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .any_ge5 (any_ge5),
    .ld      (ld),
    .add3    (add3),
    .shift   (shift),
    .busy    (busy),
    .done    (done),
    .iter    (iter)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;  // 0 ld, 1 add3, 2 shift, 3 done
    int cyc;
    int it;
  } ev_t;

  ev_t           exp_q[$];
  logic [4*D-1:0] bcd_q[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [N-1:0]  operand = '0;
  logic [W-1:0]  sreg = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, expv);
    end
  endtask

  task automatic push_conv(input int t, input logic [4*D-1:0] bcd);
    exp_q.push_back('{0, t + 1, 0});
    for (int i = 0; i < N; i++) begin
      exp_q.push_back('{1, t + 2 + 2 * i, N - i});
      exp_q.push_back('{2, t + 3 + 2 * i, N - i});
    end
    exp_q.push_back('{3, t + 2 + 2 * N, 0});
    bcd_q.push_back(bcd);
  endtask

  // Monitor: compares each presented strobe against the queue head and drives the datapath model.
  always @(negedge clk) begin
    int   n;
    int   kind;
    ev_t  e;
    logic ge5;
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        chk("missed_event", -1, e.kind);
      end
      n = int'(ld) + int'(add3) + int'(shift) + int'(done);
      if (n != 0) begin
        chk("mutex", n, 1);
        kind = ld ? 0 : add3 ? 1 : shift ? 2 : 3;
        if (exp_q.size() == 0) begin
          chk("unexpected_event", kind, -1);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", kind, e.kind);
          chk("event_cycle", cyc, e.cyc);
          chk("iter", iter, e.it);
          chk("busy", busy, (e.kind != 3));
        end
        if (ld) sreg = W'(operand);
        if (add3)
          for (int d = 0; d < D; d++)
            if (sreg[N+4*d +: 4] >= 4'd5) sreg[N+4*d +: 4] = sreg[N+4*d +: 4] + 4'd3;
        if (shift) sreg = sreg << 1;
        if (done) begin
          if (bcd_q.size() == 0) chk("bcd_unexpected", sreg[N +: 4*D], -1);
          else chk("bcd_result", sreg[N +: 4*D], bcd_q.pop_front());
        end
      end
      ge5 = 1'b0;
      for (int d = 0; d < D; d++) if (sreg[N+4*d +: 4] >= 4'd5) ge5 = 1'b1;
      any_ge5 = ge5;
    end
  end

  task automatic start_conv(input logic [N-1:0] op, input logic [4*D-1:0] bcd, output int t);
    @(negedge clk);
    operand = op;
    start   = 1'b1;
    t       = cyc;
    push_conv(t, bcd);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic chk_quiet(input string name);
    chk(name, {ld, add3, shift, busy, done, iter}, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    rst = 1'b1; start = 1'b0; any_ge5 = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset_state");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_quiet("idle_quiet");
    end

    // Single conversion
    start_conv(16'd255, 20'h00255, t);
    wait_until(t + 40);
    chk("queue_empty_255", exp_q.size(), 0);

    // Start during busy must be ignored
    start_conv(16'd65535, 20'h65535, t);
    wait_until(t + 10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(t + 45);
    chk("queue_empty_busy_start", exp_q.size(), 0);

    // Asynchronous reset mid-conversion
    start_conv(16'd1234, 20'h01234, t);
    wait_until(t + 15);
    #2 rst = 1'b1;
    exp_q.delete();
    bcd_q.delete();
    #1 chk_quiet("async_reset_immediate");
    @(negedge clk);
    chk_quiet("async_reset_hold");
    rst = 1'b0;
    start_conv(16'd4095, 20'h04095, t);
    wait_until(t + 40);
    chk("queue_empty_after_reset", exp_q.size(), 0);

    // Back-to-back with start held high
    @(negedge clk);
    operand = 16'd9999;
    start   = 1'b1;
    t       = cyc;
    push_conv(t, 20'h09999);
    push_conv(t + 35, 20'h09999);
    wait_until(t + 35);
    chk("b2b_idle_gap", {ld, add3, shift, busy, done}, 0);
    @(negedge clk);
    start = 1'b0;
    wait_until(t + 75);
    chk("queue_empty_b2b", exp_q.size(), 0);
    chk("bcd_queue_empty", bcd_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
